adc_sample_averager: RTL and testbench
======================================

Name: adc_sample_averager

Overview:
- Downstream stage of the ADC.
- Consumes the ADC's registered 10-bit samples, qualified by a per-sample strobe.
- Accumulates N = 2^LOG2_N consecutive samples and emits their rounded mean through a single-entry valid/ready output register.
- Sits between the ADC and the DAC/processing path; reduces noise and rate by a factor of N.

Parameters:
DATA_W, 10, sample and result width (matches ADC digital_out)
LOG2_N, 2, log2 of samples per average; legal range 0..6

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  block enable; low clears accumulation in progress
sample_valid  input  1  strobe: sample_in is a new ADC sample this cycle
sample_in  input  DATA_W  ADC digital_out
avg_ready  input  1  consumer accepts avg_out this cycle
clr_ovr  input  1  synchronous clear of overrun flag
avg_out  output  DATA_W  rounded mean of last N accepted samples
avg_valid  output  1  avg_out holds an unconsumed result
overrun  output  1  sticky: a completed average was dropped
sample_cnt  output  LOG2_N (min 1)  samples accumulated in current window

Behaviour:
- Reset: clock and reset are named clk/rst; rst is asynchronous, active-high.
  - Asynchronous rst forces accumulator = 0, sample_cnt = 0, avg_out = 0, avg_valid = 0, overrun = 0.
  - Reset mid-window discards partial sums.
  - Reset with avg_valid = 1 discards the held result.
- Accumulator width is DATA_W+LOG2_N; it cannot overflow.
- Sample acceptance: a sample is accepted when en & sample_valid is high on a rising edge.
- Non-final accepted sample (sample_cnt < N-1):
  - accumulator <= accumulator + sample_in.
  - sample_cnt <= sample_cnt + 1.
- Final accepted sample (sample_cnt == N-1), i.e. window completion:
  - sum = accumulator + sample_in.
  - result = (sum + 2^(LOG2_N-1)) >> LOG2_N (round half up). For LOG2_N = 0, result = sample_in.
  - result <= 2^DATA_W - 1 always holds; no saturation logic is needed.
  - accumulator <= 0; sample_cnt wraps to 0.
- Latency: avg_out/avg_valid update on the same edge that accepts the Nth sample, so they are visible the cycle after that sample is presented.
- Output handshake: transfer occurs on an edge where avg_valid & avg_ready is high.
  - Transfer with no simultaneous completion: avg_valid <= 0; avg_out holds its value.
- Completion when the output register is free (avg_valid = 0, or a transfer on the same edge): load result, avg_valid <= 1. A transfer plus a completion on the same edge is not an overrun.
- Completion while the output is busy (avg_valid = 1, avg_ready = 0):
  - The new result is dropped; the held avg_out is preserved.
  - overrun <= 1.
  - The accumulator still restarts.
- overrun is sticky until clr_ovr or rst. If clr_ovr and a new overrun event occur on the same edge, overrun = 1 (set wins).
- en = 0:
  - accumulator and sample_cnt are cleared synchronously; samples are ignored.
  - The output register and handshake continue to operate; a pending result can still be drained.
- sample_valid may be asserted on consecutive cycles; the block accepts one sample per clock with no stall. There is no backpressure to the ADC.
- avg_out must remain stable while avg_valid = 1 and avg_ready = 0.

Test Plan:
1. Basic average: rst pulse; en = 1; 4 samples 100, 101, 102, 103 (sum 406) with avg_ready = 1 → avg_valid one cycle after the 4th sample, avg_out = 102; avg_valid drops after one cycle.
2. Rounding and full scale:
   - Samples 0, 0, 0, 2 → avg_out = 1 (2 + 2 = 4, >> 2).
   - Samples 1023 ×4 → avg_out = 1023, with no wrap.
3. Backpressure and overrun: avg_ready = 0; feed 8 samples all 200 then 8 samples all 300 → first avg_out = 200 held stable, overrun = 1 after the second window; avg_ready = 1 transfers 200; clr_ovr → overrun = 0.
4. Simultaneous transfer and completion: avg_valid = 1 with avg_ready = 1 on the same edge the Nth sample arrives → new result loaded, avg_valid stays 1, overrun = 0.
5. Reset mid-window: accept 2 samples of 500, assert rst asynchronously between edges → all outputs 0 immediately; then 4 samples of 10 → avg_out = 10.
6. Enable drop: accept 3 samples of 800, deassert en one cycle, reassert, feed 4 samples of 40 → avg_out = 40 with no 800 contribution; sample_cnt = 0 during en = 0.

Source files
------------

// File: rtl/adc_sample_averager.sv
// Boxcar averager for ADC samples.
// Sums 2^LOG2_N accepted samples and presents the rounded mean through a single-entry valid/ready register.
module adc_sample_averager #(
    parameter int DATA_W = 10,
    parameter int LOG2_N = 2
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    en,
    input  logic                                    sample_valid,
    input  logic [DATA_W-1:0]                       sample_in,
    input  logic                                    avg_ready,
    input  logic                                    clr_ovr,
    output logic [DATA_W-1:0]                       avg_out,
    output logic                                    avg_valid,
    output logic                                    overrun,
    output logic [((LOG2_N < 1) ? 1 : LOG2_N)-1:0]  sample_cnt
);

    localparam int CNT_W     = (LOG2_N < 1) ? 1 : LOG2_N;
    localparam int ACC_W     = DATA_W + LOG2_N;
    localparam int HALF_SH   = (LOG2_N > 0) ? LOG2_N - 1 : 0;
    localparam int ROUND_ADD = (LOG2_N > 0) ? (1 << HALF_SH) : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_N) - 1);

    // Max sum is N*(2^DATA_W-1); adding N/2 still fits in ACC_W bits.
    function automatic logic [DATA_W-1:0] round_mean(input logic [ACC_W-1:0] sum);
        logic [ACC_W-1:0] biased;
        biased = sum + ACC_W'(ROUND_ADD);
        return DATA_W'(biased >> LOG2_N);
    endfunction

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] avg_out_q, avg_out_d;
    logic              avg_valid_q, avg_valid_d;
    logic              overrun_q, overrun_d;

    logic             accept;
    logic             complete;
    logic             xfer;
    logic [ACC_W-1:0] sum;

    always_comb begin
        accept      = en & sample_valid;
        complete    = accept & (cnt_q == CNT_LAST);
        xfer        = avg_valid_q & avg_ready;
        sum         = acc_q + ACC_W'(sample_in);

        acc_d       = acc_q;
        cnt_d       = cnt_q;
        avg_out_d   = avg_out_q;
        avg_valid_d = avg_valid_q;
        overrun_d   = overrun_q;

        if (!en) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (accept) begin
            if (complete) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (xfer) begin
            avg_valid_d = 1'b0;
        end
        if (clr_ovr) begin
            overrun_d = 1'b0;
        end

        // A same-edge drain frees the register, so the new mean may load.
        if (complete) begin
            if (!avg_valid_q || xfer) begin
                avg_out_d   = round_mean(sum);
                avg_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            avg_out_q   <= '0;
            avg_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            avg_out_q   <= avg_out_d;
            avg_valid_q <= avg_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign avg_out    = avg_out_q;
    assign avg_valid  = avg_valid_q;
    assign overrun    = overrun_q;
    assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_adc_sample_averager.sv
// Self-checking bench for adc_sample_averager: directed scenarios plus randomized traffic
// compared against a window-sum reference model.
module tb_adc_sample_averager;

    localparam int DATA_W = 10;
    localparam int LOG2_N = 2;
    localparam int N      = 1 << LOG2_N;
    localparam int CNT_W  = (LOG2_N < 1) ? 1 : LOG2_N;
    localparam int VEC_W  = DATA_W + CNT_W + 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              en = 1'b0;
    logic              sample_valid = 1'b0;
    logic [DATA_W-1:0] sample_in = '0;
    logic              avg_ready = 1'b0;
    logic              clr_ovr = 1'b0;
    logic [DATA_W-1:0] avg_out;
    logic              avg_valid;
    logic              overrun;
    logic [CNT_W-1:0]  sample_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: running window and output register contents.
    int          win_sum;
    int          win_cnt;
    logic        m_valid;
    int          m_out;
    logic        m_ovr;

    adc_sample_averager #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) dut (
        .clk(clk), .rst(rst), .en(en), .sample_valid(sample_valid),
        .sample_in(sample_in), .avg_ready(avg_ready), .clr_ovr(clr_ovr),
        .avg_out(avg_out), .avg_valid(avg_valid), .overrun(overrun),
        .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    wire [VEC_W-1:0] obs = {avg_valid, avg_out, overrun, sample_cnt};

    function automatic logic [VEC_W-1:0] exp_vec();
        return {m_valid, DATA_W'(m_out), m_ovr, CNT_W'(win_cnt)};
    endfunction

    task automatic reset_model();
        win_sum = 0;
        win_cnt = 0;
        m_valid = 1'b0;
        m_out   = 0;
        m_ovr   = 1'b0;
    endtask

    // Advance the model by one clock using the inputs currently driven, then step the DUT.
    task automatic cycle();
        int   res;
        logic done;
        done = 1'b0;
        res  = 0;
        if (!en) begin
            win_sum = 0;
            win_cnt = 0;
        end else if (sample_valid) begin
            win_sum += int'(sample_in);
            win_cnt++;
            if (win_cnt == N) begin
                res     = (win_sum + N / 2) / N;
                done    = 1'b1;
                win_sum = 0;
                win_cnt = 0;
            end
        end
        if (clr_ovr) m_ovr = 1'b0;
        if (m_valid && avg_ready) m_valid = 1'b0;
        if (done) begin
            if (!m_valid) begin
                m_out   = res;
                m_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int d);
        sample_valid = v;
        sample_in    = DATA_W'(d);
        cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        reset_model();
        @(posedge clk);
        #1;
        n_cmp++;
        if (obs !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got %h expected 0", obs);
        end
        #3 rst = 1'b0;
        en = 1'b1;
        avg_ready = 1'b1;
    endtask

    task automatic test_basic();
        for (int i = 0; i < N; i++) begin
            drive(1'b1, 100 + i);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL basic_step%0d: got %h expected %h", i, obs, exp_vec());
            end
        end
        n_cmp++;
        if (avg_valid !== 1'b1 || avg_out !== 10'd102) begin
            n_bad++;
            $display("FAIL basic_mean: got valid=%b out=%0d expected valid=1 out=102", avg_valid, avg_out);
        end
        drive(1'b0, 0);
        n_cmp++;
        if (avg_valid !== 1'b0 || avg_out !== 10'd102) begin
            n_bad++;
            $display("FAIL basic_drain: got valid=%b out=%0d expected valid=0 out=102", avg_valid, avg_out);
        end
    endtask

    task automatic test_rounding();
        int pat [2][4] = '{'{0, 0, 0, 2}, '{1023, 1023, 1023, 1023}};
        int want [2] = '{1, 1023};
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < N; i++) drive(1'b1, pat[p][i]);
            n_cmp++;
            if (avg_valid !== 1'b1 || avg_out !== DATA_W'(want[p]) || obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL rounding_%0d: got valid=%b out=%0d expected valid=1 out=%0d",
                         p, avg_valid, avg_out, want[p]);
            end
        end
        drive(1'b0, 0);
    endtask

    task automatic test_overrun();
        avg_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, (i < 8) ? 200 : 300);
            if (i >= N - 1) begin
                n_cmp++;
                if (avg_valid !== 1'b1 || avg_out !== 10'd200 || obs !== exp_vec()) begin
                    n_bad++;
                    $display("FAIL overrun_hold%0d: got valid=%b out=%0d expected valid=1 out=200",
                             i, avg_valid, avg_out);
                end
            end
        end
        n_cmp++;
        if (overrun !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun_set: got %b expected 1", overrun);
        end
        avg_ready = 1'b1;
        drive(1'b0, 0);
        n_cmp++;
        if (avg_valid !== 1'b0 || overrun !== 1'b1 || obs !== exp_vec()) begin
            n_bad++;
            $display("FAIL overrun_drain: got valid=%b ovr=%b expected valid=0 ovr=1", avg_valid, overrun);
        end
        clr_ovr = 1'b1;
        drive(1'b0, 0);
        clr_ovr = 1'b0;
        n_cmp++;
        if (overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL overrun_clear: got %b expected 0", overrun);
        end
    endtask

    task automatic test_back_to_back();
        avg_ready = 1'b0;
        for (int i = 0; i < N; i++) drive(1'b1, 50);
        for (int i = 0; i < N - 1; i++) drive(1'b1, 60);
        avg_ready = 1'b1;
        drive(1'b1, 60);
        n_cmp++;
        if (avg_valid !== 1'b1 || avg_out !== 10'd60 || overrun !== 1'b0 || obs !== exp_vec()) begin
            n_bad++;
            $display("FAIL back_to_back: got valid=%b out=%0d ovr=%b expected valid=1 out=60 ovr=0",
                     avg_valid, avg_out, overrun);
        end
        drive(1'b0, 0);
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 500);
        drive(1'b1, 500);
        sample_valid = 1'b0;
        #1 rst = 1'b1;
        reset_model();
        #1;
        n_cmp++;
        if (obs !== '0) begin
            n_bad++;
            $display("FAIL reset_async: got %h expected 0", obs);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) drive(1'b1, 10);
        n_cmp++;
        if (avg_valid !== 1'b1 || avg_out !== 10'd10 || obs !== exp_vec()) begin
            n_bad++;
            $display("FAIL reset_mid_avg: got valid=%b out=%0d expected valid=1 out=10", avg_valid, avg_out);
        end
        drive(1'b0, 0);
    endtask

    task automatic test_enable_drop();
        for (int i = 0; i < N - 1; i++) drive(1'b1, 800);
        en = 1'b0;
        drive(1'b1, 800);
        n_cmp++;
        if (sample_cnt !== '0 || obs !== exp_vec()) begin
            n_bad++;
            $display("FAIL enable_cnt: got cnt=%0d expected 0", sample_cnt);
        end
        en = 1'b1;
        for (int i = 0; i < N; i++) drive(1'b1, 40);
        n_cmp++;
        if (avg_valid !== 1'b1 || avg_out !== 10'd40 || obs !== exp_vec()) begin
            n_bad++;
            $display("FAIL enable_avg: got valid=%b out=%0d expected valid=1 out=40", avg_valid, avg_out);
        end
        drive(1'b0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            en        = ($urandom_range(0, 9) != 0);
            avg_ready = $urandom_range(0, 1);
            clr_ovr   = ($urandom_range(0, 19) == 0);
            drive(($urandom_range(0, 9) < 7), $urandom_range(0, 1023));
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL random_%0d: got %h expected %h", i, obs, exp_vec());
            end
        end
        clr_ovr = 1'b0;
        en      = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_model();
        test_reset();
        test_basic();
        test_rounding();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        test_enable_drop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
